// File: rtl/lru_cam_cache_if.sv
// rtl/lru_cam_cache_if.sv - request/response bus of the LRU CAM cache
interface lru_cam_cache_if #(
   parameter int KEY_WIDTH  = 8,
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_SIZE  = 3
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_write;
   logic [KEY_WIDTH-1:0]  req_key;
   logic [DATA_WIDTH-1:0] req_data;
   logic                  resp_valid;
   logic                  resp_ready;
   logic                  resp_hit;
   logic [ADDR_SIZE-1:0]  resp_index;
   logic [DATA_WIDTH-1:0] resp_data;

   modport master (
      output req_valid, req_write, req_key, req_data, resp_ready,
      input  req_ready, resp_valid, resp_hit, resp_index, resp_data
   );

   modport slave (
      input  req_valid, req_write, req_key, req_data, resp_ready,
      output req_ready, resp_valid, resp_hit, resp_index, resp_data
   );
endinterface

// File: rtl/lru_cam_cache.sv
// rtl/lru_cam_cache.sv - fully associative key/data cache kept in recency order (optional EVICT_OUT_EN)
module lru_cam_cache #(
   parameter int KEY_WIDTH  = 8,
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_SIZE  = $clog2(DEPTH)
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_flush,
   lru_cam_cache_if.slave        bus,
   output logic [ADDR_SIZE:0]    o_occupancy
`ifdef EVICT_OUT_EN
   ,
   output logic                  o_evict_valid,
   output logic [KEY_WIDTH-1:0]  o_evict_key,
   output logic [DATA_WIDTH-1:0] o_evict_data
`endif
);

   localparam logic [ADDR_SIZE:0] LP_FULL = (ADDR_SIZE+1)'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_COMPARE,
      S_UPDATE,
      S_RESP
   } state_t;

   state_t                r_state;
   state_t                w_next_state;
   logic                  w_req_ready;
   logic                  w_accept;

   // entry array, index 0 is the most recently used
   logic [DEPTH-1:0]      r_valid;
   logic [KEY_WIDTH-1:0]  r_key  [DEPTH];
   logic [DATA_WIDTH-1:0] r_data [DEPTH];
   logic [ADDR_SIZE:0]    r_occupancy;

   // latched request and registered compare result
   logic                  r_req_write;
   logic [KEY_WIDTH-1:0]  r_req_key;
   logic [DATA_WIDTH-1:0] r_req_data;
   logic                  r_hit;
   logic [ADDR_SIZE-1:0]  r_index;
   logic [DATA_WIDTH-1:0] r_resp_data;

   logic [DEPTH-1:0]      w_eq;
   logic                  w_hit;
   logic [ADDR_SIZE-1:0]  w_hit_idx;

`ifdef EVICT_OUT_EN
   logic                  r_evict_valid;
   logic [KEY_WIDTH-1:0]  r_evict_key;
   logic [DATA_WIDTH-1:0] r_evict_data;
`endif

   assign w_accept = (r_state == S_IDLE) && bus.req_valid;

   // state register
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // next-state and handshake decode; flush drops whatever is in flight
   always_comb begin
      w_next_state = r_state;
      w_req_ready  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_req_ready = 1'b1;
            if (bus.req_valid) begin
               w_next_state = S_COMPARE;
            end
         end
         S_COMPARE: w_next_state = S_UPDATE;
         S_UPDATE:  w_next_state = S_RESP;
         S_RESP: begin
            if (bus.resp_ready) begin
               w_next_state = S_IDLE;
            end
         end
         default:   w_next_state = S_IDLE;
      endcase
      if (i_flush) begin
         w_next_state = S_IDLE;
      end
   end

   // parallel key compare, lowest matching index wins
   always_comb begin
      w_eq      = '0;
      w_hit_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_eq[i] = r_valid[i] && (r_key[i] == r_req_key);
      end
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (w_eq[i]) begin
            w_hit_idx = ADDR_SIZE'(i);
         end
      end
      w_hit = |w_eq;
   end

   // request latch and compare result registers
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_req_write <= 1'b0;
         r_req_key   <= '0;
         r_req_data  <= '0;
         r_hit       <= 1'b0;
         r_index     <= '0;
         r_resp_data <= '0;
      end else if (!i_flush) begin
         if (w_accept) begin
            r_req_write <= bus.req_write;
            r_req_key   <= bus.req_key;
            r_req_data  <= bus.req_data;
         end
         if (r_state == S_COMPARE) begin
            r_hit       <= w_hit;
            r_index     <= w_hit_idx;
            r_resp_data <= w_hit ? r_data[w_hit_idx] : '0;
         end
      end
   end

   // array update: move a hit to the front, or push a new entry on a write miss
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_valid     <= '0;
         r_occupancy <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_key[i]  <= '0;
            r_data[i] <= '0;
         end
      end else if (i_flush) begin
         r_valid     <= '0;
         r_occupancy <= '0;
      end else if (r_state == S_UPDATE) begin
         if (r_hit) begin
            for (int i = 1; i < DEPTH; i++) begin
               if (i <= int'(r_index)) begin
                  r_valid[i] <= r_valid[i-1];
                  r_key[i]   <= r_key[i-1];
                  r_data[i]  <= r_data[i-1];
               end
            end
            r_valid[0] <= 1'b1;
            r_key[0]   <= r_key[r_index];
            r_data[0]  <= r_req_write ? r_req_data : r_data[r_index];
         end else if (r_req_write) begin
            for (int i = 1; i < DEPTH; i++) begin
               r_valid[i] <= r_valid[i-1];
               r_key[i]   <= r_key[i-1];
               r_data[i]  <= r_data[i-1];
            end
            r_valid[0] <= 1'b1;
            r_key[0]   <= r_req_key;
            r_data[0]  <= r_req_data;
            if (r_occupancy != LP_FULL) begin
               r_occupancy <= r_occupancy + 1'b1;
            end
         end
      end
   end

`ifdef EVICT_OUT_EN
   // capture the displaced tail entry of a write miss, shown for the response only
   always_ff @(posedge i_clk) begin
      if (!i_reset || i_flush) begin
         r_evict_valid <= 1'b0;
         r_evict_key   <= '0;
         r_evict_data  <= '0;
      end else if (r_state == S_UPDATE) begin
         if (!r_hit && r_req_write && r_valid[DEPTH-1]) begin
            r_evict_valid <= 1'b1;
            r_evict_key   <= r_key[DEPTH-1];
            r_evict_data  <= r_data[DEPTH-1];
         end else begin
            r_evict_valid <= 1'b0;
            r_evict_key   <= '0;
            r_evict_data  <= '0;
         end
      end else if (r_state == S_RESP && bus.resp_ready) begin
         r_evict_valid <= 1'b0;
         r_evict_key   <= '0;
         r_evict_data  <= '0;
      end
   end

   assign o_evict_valid = r_evict_valid;
   assign o_evict_key   = r_evict_key;
   assign o_evict_data  = r_evict_data;
`endif

   assign bus.req_ready  = w_req_ready;
   assign bus.resp_valid = (r_state == S_RESP);
   assign bus.resp_hit   = r_hit;
   assign bus.resp_index = r_index;
   assign bus.resp_data  = r_resp_data;
   assign o_occupancy    = r_occupancy;

endmodule

// File: tb/tb_lru_cam_cache.sv
// tb/tb_lru_cam_cache.sv - scoreboard bench for lru_cam_cache at DEPTH=4
module tb_lru_cam_cache;

   logic       i_clk;
   logic       i_reset;
   logic       i_flush;
   logic [2:0] o_occupancy;
`ifdef EVICT_OUT_EN
   logic       o_evict_valid;
   logic [7:0] o_evict_key;
   logic [7:0] o_evict_data;
`endif

   lru_cam_cache_if #(.KEY_WIDTH(8), .DATA_WIDTH(8), .ADDR_SIZE(2)) bus ();

   lru_cam_cache #(.KEY_WIDTH(8), .DATA_WIDTH(8), .DEPTH(4)) dut (
      .i_clk       (i_clk),
      .i_reset     (i_reset),
      .i_flush     (i_flush),
      .bus         (bus),
      .o_occupancy (o_occupancy)
`ifdef EVICT_OUT_EN
      ,
      .o_evict_valid (o_evict_valid),
      .o_evict_key   (o_evict_key),
      .o_evict_data  (o_evict_data)
`endif
   );

   typedef struct packed {
      logic       wr;
      logic [7:0] key;
      logic [7:0] wdata;
      logic       hit;
      logic [1:0] idx;
      logic [7:0] rdata;
      logic [2:0] occ;
      logic       ev_v;
      logic [7:0] ev_k;
   } op_t;

   op_t sb[$];
   int  checks = 0;
   int  errors = 0;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // drive one request, wait (bounded) for its response, capture it and acknowledge
   task automatic run_op(input logic wr, input logic [7:0] key, input logic [7:0] wdata,
                         output logic hit, output logic [1:0] idx, output logic [7:0] rdata,
                         output int lat, output logic ev_v, output logic [7:0] ev_k);
      int guard;
      bus.req_write  = wr;
      bus.req_key    = key;
      bus.req_data   = wdata;
      bus.req_valid  = 1'b1;
      bus.resp_ready = 1'b0;
      guard = 0;
      while (!bus.req_ready && guard < 50) begin
         @(posedge i_clk); #1;
         guard++;
      end
      @(posedge i_clk); #1;
      bus.req_valid = 1'b0;
      lat = 1;
      while (!bus.resp_valid && lat < 50) begin
         @(posedge i_clk); #1;
         lat++;
      end
      hit   = bus.resp_hit;
      idx   = bus.resp_index;
      rdata = bus.resp_data;
`ifdef EVICT_OUT_EN
      ev_v = o_evict_valid;
      ev_k = o_evict_key;
`else
      ev_v = 1'b0;
      ev_k = 8'h00;
`endif
      bus.resp_ready = 1'b1;
      @(posedge i_clk); #1;
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset();
      i_reset        = 1'b0;
      i_flush        = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_key    = 8'h00;
      bus.req_data   = 8'h00;
      bus.resp_ready = 1'b0;
      repeat (3) @(posedge i_clk);
      #1;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got %0b exp 0", bus.resp_valid); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %0b exp 1", bus.req_ready); end
      checks++; if (o_occupancy !== 3'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", o_occupancy); end
      checks++; if ({bus.resp_hit, bus.resp_index, bus.resp_data} !== 11'd0) begin errors++; $display("FAIL reset_resp got hit=%0b idx=%0d data=%h exp all 0", bus.resp_hit, bus.resp_index, bus.resp_data); end
`ifdef EVICT_OUT_EN
      checks++; if ({o_evict_valid, o_evict_key, o_evict_data} !== 17'd0) begin errors++; $display("FAIL reset_evict got %0b %h %h exp 0", o_evict_valid, o_evict_key, o_evict_data); end
`endif
      i_reset = 1'b1;
      @(posedge i_clk); #1;
   endtask

   // cold start: every lookup misses, including key 0x00 which matches the cleared key bits
   task automatic test_cold_miss();
      logic h; logic [1:0] ix; logic [7:0] d; int lat; logic ev; logic [7:0] ek;
      op_t e;
      sb.push_back('{wr:1'b0, key:8'h11, wdata:8'h00, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd0, ev_v:1'b0, ev_k:8'h00});
      run_op(1'b0, 8'h11, 8'h00, h, ix, d, lat, ev, ek);
      e = sb.pop_front();
      checks++; if ({h, ix, d} !== {e.hit, e.idx, e.rdata}) begin errors++; $display("FAIL cold_read got hit=%0b idx=%0d data=%h exp hit=%0b idx=%0d data=%h", h, ix, d, e.hit, e.idx, e.rdata); end
      checks++; if (lat !== 3) begin errors++; $display("FAIL cold_latency got %0d exp 3", lat); end
      checks++; if (o_occupancy !== e.occ) begin errors++; $display("FAIL cold_occupancy got %0d exp %0d", o_occupancy, e.occ); end
      sb.push_back('{wr:1'b0, key:8'h00, wdata:8'h00, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd0, ev_v:1'b0, ev_k:8'h00});
      run_op(1'b0, 8'h00, 8'h00, h, ix, d, lat, ev, ek);
      e = sb.pop_front();
      checks++; if ({h, ix, d} !== {e.hit, e.idx, e.rdata}) begin errors++; $display("FAIL cold_invalid_key0 got hit=%0b idx=%0d data=%h exp miss", h, ix, d); end
   endtask

   task automatic test_fill_and_hit();
      op_t ops[5];
      logic h; logic [1:0] ix; logic [7:0] d; int lat; logic ev; logic [7:0] ek;
      op_t e;
      ops[0] = '{wr:1'b1, key:8'h11, wdata:8'hA1, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd1, ev_v:1'b0, ev_k:8'h00};
      ops[1] = '{wr:1'b1, key:8'h22, wdata:8'hA2, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd2, ev_v:1'b0, ev_k:8'h00};
      ops[2] = '{wr:1'b1, key:8'h33, wdata:8'hA3, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd3, ev_v:1'b0, ev_k:8'h00};
      ops[3] = '{wr:1'b0, key:8'h11, wdata:8'h00, hit:1'b1, idx:2'd2, rdata:8'hA1, occ:3'd3, ev_v:1'b0, ev_k:8'h00};
      ops[4] = '{wr:1'b0, key:8'h11, wdata:8'h00, hit:1'b1, idx:2'd0, rdata:8'hA1, occ:3'd3, ev_v:1'b0, ev_k:8'h00};
      for (int i = 0; i < 5; i++) begin
         sb.push_back(ops[i]);
         run_op(ops[i].wr, ops[i].key, ops[i].wdata, h, ix, d, lat, ev, ek);
         e = sb.pop_front();
         checks++; if ({h, ix, d} !== {e.hit, e.idx, e.rdata}) begin errors++; $display("FAIL fill_op%0d key=%h got hit=%0b idx=%0d data=%h exp hit=%0b idx=%0d data=%h", i, e.key, h, ix, d, e.hit, e.idx, e.rdata); end
         checks++; if (o_occupancy !== e.occ) begin errors++; $display("FAIL fill_occ%0d got %0d exp %0d", i, o_occupancy, e.occ); end
      end
   endtask

   // order is 0x11,0x33,0x22; the fourth key fills, the fifth evicts 0x22
   task automatic test_evict();
      op_t ops[3];
      logic h; logic [1:0] ix; logic [7:0] d; int lat; logic ev; logic [7:0] ek;
      op_t e;
      ops[0] = '{wr:1'b1, key:8'h44, wdata:8'hA4, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd4, ev_v:1'b0, ev_k:8'h00};
      ops[1] = '{wr:1'b1, key:8'h55, wdata:8'hA5, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd4, ev_v:1'b1, ev_k:8'h22};
      ops[2] = '{wr:1'b0, key:8'h22, wdata:8'h00, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd4, ev_v:1'b0, ev_k:8'h00};
      for (int i = 0; i < 3; i++) begin
         sb.push_back(ops[i]);
         run_op(ops[i].wr, ops[i].key, ops[i].wdata, h, ix, d, lat, ev, ek);
         e = sb.pop_front();
         checks++; if ({h, ix, d} !== {e.hit, e.idx, e.rdata}) begin errors++; $display("FAIL evict_op%0d key=%h got hit=%0b idx=%0d data=%h exp hit=%0b idx=%0d data=%h", i, e.key, h, ix, d, e.hit, e.idx, e.rdata); end
         checks++; if (o_occupancy !== e.occ) begin errors++; $display("FAIL evict_occ%0d got %0d exp %0d", i, o_occupancy, e.occ); end
`ifdef EVICT_OUT_EN
         checks++; if ({ev, ek} !== {e.ev_v, e.ev_k}) begin errors++; $display("FAIL evict_out%0d got v=%0b key=%h exp v=%0b key=%h", i, ev, ek, e.ev_v, e.ev_k); end
`endif
      end
   endtask

   // order is 0x55,0x44,0x11,0x33; writing 0x33 updates in place and moves it to the front
   task automatic test_write_update();
      op_t ops[3];
      logic h; logic [1:0] ix; logic [7:0] d; int lat; logic ev; logic [7:0] ek;
      op_t e;
      ops[0] = '{wr:1'b1, key:8'h33, wdata:8'hB3, hit:1'b1, idx:2'd3, rdata:8'hA3, occ:3'd4, ev_v:1'b0, ev_k:8'h00};
      ops[1] = '{wr:1'b0, key:8'h33, wdata:8'h00, hit:1'b1, idx:2'd0, rdata:8'hB3, occ:3'd4, ev_v:1'b0, ev_k:8'h00};
      ops[2] = '{wr:1'b0, key:8'h11, wdata:8'h00, hit:1'b1, idx:2'd3, rdata:8'hA1, occ:3'd4, ev_v:1'b0, ev_k:8'h00};
      for (int i = 0; i < 3; i++) begin
         sb.push_back(ops[i]);
         run_op(ops[i].wr, ops[i].key, ops[i].wdata, h, ix, d, lat, ev, ek);
         e = sb.pop_front();
         checks++; if ({h, ix, d} !== {e.hit, e.idx, e.rdata}) begin errors++; $display("FAIL update_op%0d key=%h got hit=%0b idx=%0d data=%h exp hit=%0b idx=%0d data=%h", i, e.key, h, ix, d, e.hit, e.idx, e.rdata); end
         checks++; if (o_occupancy !== e.occ) begin errors++; $display("FAIL update_occ%0d got %0d exp %0d", i, o_occupancy, e.occ); end
      end
   endtask

   task automatic test_flush();
      logic h; logic [1:0] ix; logic [7:0] d; int lat; logic ev; logic [7:0] ek;
      int seen;
      op_t e;
      bus.req_write = 1'b0;
      bus.req_key   = 8'h11;
      bus.req_valid = 1'b1;
      @(posedge i_clk); #1;
      bus.req_valid = 1'b0;
      @(posedge i_clk); #1;
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_flush = 1'b0;
      checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL flush_resp_valid got %0b exp 0", bus.resp_valid); end
      checks++; if (o_occupancy !== 3'd0) begin errors++; $display("FAIL flush_occupancy got %0d exp 0", o_occupancy); end
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL flush_req_ready got %0b exp 1", bus.req_ready); end
      seen = 0;
      repeat (4) begin
         @(posedge i_clk); #1;
         if (bus.resp_valid) seen++;
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_resp got %0d response cycles exp 0", seen); end
      sb.push_back('{wr:1'b0, key:8'h55, wdata:8'h00, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd0, ev_v:1'b0, ev_k:8'h00});
      run_op(1'b0, 8'h55, 8'h00, h, ix, d, lat, ev, ek);
      e = sb.pop_front();
      checks++; if ({h, ix, d} !== {e.hit, e.idx, e.rdata}) begin errors++; $display("FAIL flush_read got hit=%0b idx=%0d data=%h exp miss", h, ix, d); end
   endtask

   // stall the response, keep a second request pending, then release it back-to-back
   task automatic test_back_to_back();
      logic h; logic [1:0] ix; logic [7:0] d; int lat; logic ev; logic [7:0] ek;
      int guard;
      op_t e;
      sb.push_back('{wr:1'b1, key:8'h66, wdata:8'hA6, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd1, ev_v:1'b0, ev_k:8'h00});
      run_op(1'b1, 8'h66, 8'hA6, h, ix, d, lat, ev, ek);
      e = sb.pop_front();
      checks++; if ({h, ix, d, o_occupancy} !== {e.hit, e.idx, e.rdata, e.occ}) begin errors++; $display("FAIL b2b_write got hit=%0b idx=%0d data=%h occ=%0d exp miss occ=%0d", h, ix, d, o_occupancy, e.occ); end

      sb.push_back('{wr:1'b0, key:8'h66, wdata:8'h00, hit:1'b1, idx:2'd0, rdata:8'hA6, occ:3'd1, ev_v:1'b0, ev_k:8'h00});
      bus.req_write = 1'b0;
      bus.req_key   = 8'h66;
      bus.req_valid = 1'b1;
      @(posedge i_clk); #1;
      bus.req_valid = 1'b0;
      guard = 0;
      while (!bus.resp_valid && guard < 50) begin
         @(posedge i_clk); #1;
         guard++;
      end
      sb.push_back('{wr:1'b0, key:8'h77, wdata:8'h00, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd1, ev_v:1'b0, ev_k:8'h00});
      bus.req_key   = 8'h77;
      bus.req_valid = 1'b1;
      e = sb.pop_front();
      for (int c = 0; c < 5; c++) begin
         @(posedge i_clk); #1;
         checks++;
         if ({bus.resp_valid, bus.req_ready, bus.resp_hit, bus.resp_index, bus.resp_data} !== {1'b1, 1'b0, e.hit, e.idx, e.rdata}) begin
            errors++;
            $display("FAIL stall_cycle%0d got valid=%0b ready=%0b hit=%0b idx=%0d data=%h exp valid=1 ready=0 hit=%0b idx=%0d data=%h",
                     c, bus.resp_valid, bus.req_ready, bus.resp_hit, bus.resp_index, bus.resp_data, e.hit, e.idx, e.rdata);
         end
      end
      bus.resp_ready = 1'b1;
      @(posedge i_clk); #1;
      bus.resp_ready = 1'b0;
      checks++; if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin errors++; $display("FAIL b2b_idle got valid=%0b ready=%0b exp valid=0 ready=1", bus.resp_valid, bus.req_ready); end
      @(posedge i_clk); #1;
      bus.req_valid = 1'b0;
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got ready=%0b exp 0", bus.req_ready); end
      lat = 1;
      while (!bus.resp_valid && lat < 50) begin
         @(posedge i_clk); #1;
         lat++;
      end
      e = sb.pop_front();
      checks++; if ({bus.resp_hit, bus.resp_index, bus.resp_data, lat} !== {e.hit, e.idx, e.rdata, 32'd3}) begin errors++; $display("FAIL b2b_second got hit=%0b idx=%0d data=%h lat=%0d exp miss lat=3", bus.resp_hit, bus.resp_index, bus.resp_data, lat); end
      bus.resp_ready = 1'b1;
      @(posedge i_clk); #1;
      bus.resp_ready = 1'b0;
   endtask

   task automatic test_reset_in_resp();
      logic h; logic [1:0] ix; logic [7:0] d; int lat; logic ev; logic [7:0] ek;
      int guard;
      op_t e;
      sb.push_back('{wr:1'b0, key:8'h66, wdata:8'h00, hit:1'b1, idx:2'd0, rdata:8'hA6, occ:3'd1, ev_v:1'b0, ev_k:8'h00});
      bus.req_write  = 1'b0;
      bus.req_key    = 8'h66;
      bus.req_valid  = 1'b1;
      bus.resp_ready = 1'b0;
      @(posedge i_clk); #1;
      bus.req_valid = 1'b0;
      guard = 0;
      while (!bus.resp_valid && guard < 50) begin
         @(posedge i_clk); #1;
         guard++;
      end
      e = sb.pop_front();
      checks++; if ({bus.resp_valid, bus.resp_hit, bus.resp_index, bus.resp_data} !== {1'b1, e.hit, e.idx, e.rdata}) begin errors++; $display("FAIL rir_resp got valid=%0b hit=%0b idx=%0d data=%h exp valid=1 hit=%0b idx=%0d data=%h", bus.resp_valid, bus.resp_hit, bus.resp_index, bus.resp_data, e.hit, e.idx, e.rdata); end
      i_reset = 1'b0;
      i_flush = 1'b1;
      @(posedge i_clk); #1;
      i_reset = 1'b0;
      i_flush = 1'b0;
      checks++; if ({bus.resp_valid, bus.resp_hit, bus.resp_data, bus.req_ready, o_occupancy} !== {1'b0, 1'b0, 8'h00, 1'b1, 3'd0}) begin errors++; $display("FAIL rir_after got valid=%0b hit=%0b data=%h ready=%0b occ=%0d exp 0 0 00 1 0", bus.resp_valid, bus.resp_hit, bus.resp_data, bus.req_ready, o_occupancy); end
      i_reset = 1'b1;
      @(posedge i_clk); #1;
      sb.push_back('{wr:1'b0, key:8'h66, wdata:8'h00, hit:1'b0, idx:2'd0, rdata:8'h00, occ:3'd0, ev_v:1'b0, ev_k:8'h00});
      run_op(1'b0, 8'h66, 8'h00, h, ix, d, lat, ev, ek);
      e = sb.pop_front();
      checks++; if ({h, ix, d, o_occupancy} !== {e.hit, e.idx, e.rdata, e.occ}) begin errors++; $display("FAIL rir_read got hit=%0b idx=%0d data=%h occ=%0d exp miss occ=0", h, ix, d, o_occupancy); end
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_fill_and_hit();
      test_evict();
      test_write_update();
      test_flush();
      test_back_to_back();
      test_reset_in_resp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
